// File: rtl/cartoon_pkg.sv
// Shared pixel/window types and window slice offsets
// used by the 3x3 feeder and the mean-average filter.
package cartoon_pkg;
   localparam int PIX_W   = 24;
   localparam int WIN_PIX = 9;

   typedef logic [PIX_W-1:0]         pixel_t;
   typedef logic [PIX_W*WIN_PIX-1:0] window_t;

   localparam int P0_LSB = 192;
   localparam int P1_LSB = 168;
   localparam int P2_LSB = 144;
   localparam int P3_LSB = 120;
   localparam int P4_LSB = 96;
   localparam int P5_LSB = 72;
   localparam int P6_LSB = 48;
   localparam int P7_LSB = 24;
   localparam int P8_LSB = 0;

   function automatic int p_lsb(input int k);
      return (WIN_PIX - 1 - k) * PIX_W;
   endfunction
endpackage

// File: rtl/window_feeder_3x3_if.sv
// Pixel-stream input and 3x3 window output bundle
// between frame reader, feeder and mean_average.
interface window_feeder_3x3_if;
   import cartoon_pkg::*;

   logic    in_valid;
   logic    in_sof;
   pixel_t  in_pixel;
   logic    in_ready;
   logic    win_enable;
   window_t pixelData;
   logic    pixel_done;
   logic    win_last;

   modport master (
      input  in_valid,
      input  in_sof,
      input  in_pixel,
      input  pixel_done,
      output in_ready,
      output win_enable,
      output pixelData,
      output win_last
   );

   modport slave (
      output in_valid,
      output in_sof,
      output in_pixel,
      output pixel_done,
      input  in_ready,
      input  win_enable,
      input  pixelData,
      input  win_last
   );
endinterface

// File: rtl/window_feeder_3x3_line_buffer.sv
// One image line of pixels: combinational read,
// synchronous write at the same address.
module line_buffer
   import cartoon_pkg::*;
#(
   parameter int DEPTH = 640
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  pixel_t                   wr_data,
   output pixel_t                   rd_data
);
   pixel_t mem [DEPTH];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
   end
endmodule

// File: rtl/window_feeder_3x3.sv
// Raster pixel stream to 3x3 windows: two line buffers,
// a shifting window and an accept/issue/wait handshake.
module window_feeder_3x3
   import cartoon_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input logic                 clk,
   input logic                 n_rst,
   window_feeder_3x3_if.master bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

   localparam logic [1:0] ACCEPT = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;

   logic [1:0]    state, state_d;
   logic [CW-1:0] col, ecol, col_d;
   logic [RW-1:0] row, erow, row_d;
   pixel_t        lb0_q, lb1_q;
   window_t       win_q, win_d;
   logic          hs, go, last;

   assign hs   = bus.in_valid && bus.in_ready;
   assign ecol = bus.in_sof ? '0 : col;
   assign erow = bus.in_sof ? '0 : row;
   assign go   = (erow >= RW'(2)) && (ecol >= CW'(2));
   assign last = (ecol == COL_MAX) && (erow == ROW_MAX);

   assign bus.win_enable = (state == ISSUE);

   line_buffer #(.DEPTH(IMG_W)) u_lb0 (
      .clk     (clk),
      .wr_en   (hs),
      .addr    (ecol),
      .wr_data (bus.in_pixel),
      .rd_data (lb0_q)
   );

   line_buffer #(.DEPTH(IMG_W)) u_lb1 (
      .clk     (clk),
      .wr_en   (hs),
      .addr    (ecol),
      .wr_data (lb0_q),
      .rd_data (lb1_q)
   );

   // shift left; new right column is {older line, old line, incoming}
   always_comb begin
      win_d = win_q;
      for (int r = 0; r < 3; r++) begin
         win_d[p_lsb(3*r) +: PIX_W]   = win_q[p_lsb(3*r+1) +: PIX_W];
         win_d[p_lsb(3*r+1) +: PIX_W] = win_q[p_lsb(3*r+2) +: PIX_W];
      end
      win_d[P2_LSB +: PIX_W] = lb1_q;
      win_d[P5_LSB +: PIX_W] = lb0_q;
      win_d[P8_LSB +: PIX_W] = bus.in_pixel;
   end

   always_comb begin
      col_d = ecol + CW'(1);
      row_d = erow;
      if (ecol == COL_MAX) begin
         col_d = '0;
         row_d = (erow == ROW_MAX) ? '0 : erow + RW'(1);
      end
   end

   always_comb begin
      state_d = state;
      unique case (1'b1)
         (state == ACCEPT): if (hs && go) state_d = ISSUE;
         (state == ISSUE):  state_d = WAIT;
         (state == WAIT):   if (bus.pixel_done) state_d = ACCEPT;
         default:           state_d = ACCEPT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state         <= ACCEPT;
         bus.in_ready  <= 1'b0;
         bus.pixelData <= '0;
         bus.win_last  <= 1'b0;
         col           <= '0;
         row           <= '0;
         win_q         <= '0;
      end else begin
         state        <= state_d;
         bus.in_ready <= (state_d == ACCEPT);
         if (hs) begin
            win_q <= win_d;
            col   <= col_d;
            row   <= row_d;
         end
         if (hs && go) begin
            bus.pixelData <= win_d;
            bus.win_last  <= last;
         end
      end
   end
endmodule

// File: tb/tb_window_feeder_3x3.sv
// Directed bench for window_feeder_3x3 on a 4x4 image
// with a delayed pixel_done responder.
module tb_window_feeder_3x3;
   import cartoon_pkg::*;

   typedef struct {
      int      center;
      window_t data;
      bit      last;
   } vec_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   done_delay = 1;
   int   cd = 0;
   int   hs_cyc [16];

   window_t cap_data [$];
   bit      cap_last [$];
   int      cap_cyc [$];
   vec_t    vec [4];

   window_feeder_3x3_if bus ();

   window_feeder_3x3 #(.IMG_W(4), .IMG_H(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      bus.pixel_done = 1'b0;
      if (!n_rst) cd = 0;
      else if (cd > 0) begin
         cd--;
         if (cd == 0) bus.pixel_done = 1'b1;
      end
      if (bus.win_enable === 1'b1) begin
         cap_data.push_back(bus.pixelData);
         cap_last.push_back(bus.win_last);
         cap_cyc.push_back(cyc);
         cd = done_delay;
      end
   end

   function automatic window_t mkw(input int a, b, c, d, e, f, g, h, i);
      return {24'(a), 24'(b), 24'(c), 24'(d), 24'(e),
              24'(f), 24'(g), 24'(h), 24'(i)};
   endfunction

   task automatic chk_i(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_w(input string nm, input window_t act, input window_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send(input int idx, input int val, input bit sof, input bit gaps);
      int guard = 0;
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.in_pixel = 24'(val);
      bus.in_sof   = sof;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: idx %0d not accepted in 200 cycles", idx);
      end
      @(negedge clk);
      hs_cyc[idx] = cyc;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < 16; i++) send(i, i, i == 0, gaps);
      repeat (8) @(negedge clk);
   endtask

   task automatic check_frame(input int base, input string tag);
      int n;
      n = cap_data.size() - base;
      chk_i({tag, "_count"}, n, 4);
      for (int k = 0; k < 4; k++) begin
         if (base + k < cap_data.size()) begin
            chk_w($sformatf("%s_win%0d", tag, k), cap_data[base+k], vec[k].data);
            chk_i($sformatf("%s_last%0d", tag, k), int'(cap_last[base+k]), int'(vec[k].last));
            chk_i($sformatf("%s_lat%0d", tag, k), cap_cyc[base+k], hs_cyc[vec[k].center]);
         end
      end
   endtask

   task automatic do_reset(input string tag);
      n_rst = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      repeat (2) @(negedge clk);
      chk_i({tag, "_rst_ready"}, int'(bus.in_ready), 0);
      chk_i({tag, "_rst_wen"}, int'(bus.win_enable), 0);
      chk_w({tag, "_rst_data"}, bus.pixelData, '0);
      chk_i({tag, "_rst_last"}, int'(bus.win_last), 0);
      n_rst = 1'b1;
      @(negedge clk);
      chk_i({tag, "_ready_after_rst"}, int'(bus.in_ready), 1);
   endtask

   initial begin
      int base;
      window_t pd0;
      bit hold_ok;
      vec[0] = '{10, mkw(0, 1, 2, 4, 5, 6, 8, 9, 10), 1'b0};
      vec[1] = '{11, mkw(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
      vec[2] = '{14, mkw(4, 5, 6, 8, 9, 10, 12, 13, 14), 1'b0};
      vec[3] = '{15, mkw(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
      bus.in_pixel = '0;

      do_reset("init");

      base = cap_data.size();
      send_frame(1'b0);
      check_frame(base, "s1");

      // pixel_done held off for 20 cycles on every window
      done_delay = 21;
      base = cap_data.size();
      for (int i = 0; i <= 10; i++) send(i, i, i == 0, 1'b0);
      pd0 = bus.pixelData;
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.pixelData !== pd0) hold_ok = 1'b0;
      end
      chk_i("s3_hold_stable", int'(hold_ok), 1);
      chk_w("s3_hold_data", pd0, vec[0].data);
      @(negedge clk);
      chk_i("s3_ready_in_done_cycle", int'(bus.in_ready), 0);
      @(negedge clk);
      chk_i("s3_ready_after_done", int'(bus.in_ready), 1);
      for (int i = 11; i < 16; i++) send(i, i, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      check_frame(base, "s3");
      done_delay = 1;

      base = cap_data.size();
      send_frame(1'b1);
      check_frame(base, "s4");

      // truncated frame: six pixels, then a new frame with sof
      base = cap_data.size();
      for (int i = 0; i < 6; i++) send(i, 24'hA00000 + i, i == 0, 1'b0);
      send_frame(1'b0);
      check_frame(base, "s5");

      // reset while a window is outstanding
      done_delay = 50;
      base = cap_data.size();
      for (int i = 0; i <= 10; i++) send(i, i, i == 0, 1'b0);
      @(negedge clk);
      chk_i("s6_in_wait_ready", int'(bus.in_ready), 0);
      chk_w("s6_in_wait_data", bus.pixelData, vec[0].data);
      n_rst = 1'b0;
      @(negedge clk);
      chk_i("s6_rst_ready", int'(bus.in_ready), 0);
      chk_i("s6_rst_wen", int'(bus.win_enable), 0);
      chk_w("s6_rst_data", bus.pixelData, '0);
      done_delay = 1;
      n_rst = 1'b1;
      repeat (6) @(negedge clk);
      chk_i("s6_abandoned", cap_data.size() - base, 1);
      base = cap_data.size();
      send_frame(1'b0);
      check_frame(base, "s6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
